// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: word type, FSM encoding, latency bound.
package data_types;

    typedef logic [31:0] word32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_resp_state_t;

    localparam int DMEM_MAX_LATENCY = 15;

endpackage

// File: rtl/dmem_responder_ram.sv
// Word-addressed single-port storage; the enable is the RESP-entry strobe, so each
// accepted request touches the array exactly once.
module dmem_ram
    import data_types::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  word32_t               wdata,
    output word32_t               rdata
);

    word32_t mem [2**DEPTH_LOG2];

    // Contents are deliberately not reset; rdata is masked by the owner outside RESP.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency dmem target: captures a request pulse, counts out LATENCY cycles,
// accesses the array on entry to RESP and returns a one-cycle done pulse.
module dmem_responder
    import data_types::*;
#(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        dmem_read_i,
    input  logic        dmem_write_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_data_i,
    output logic [31:0] dmem_rd_data_o,
    output logic        dmem_done_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    dmem_resp_state_t      state;
    logic [3:0]            cnt;
    logic                  op_write;
    logic                  cap_oob;
    logic [DEPTH_LOG2-1:0] cap_idx;
    word32_t               cap_data;

    logic                  req_any, req_valid, accept, in_oob, enter_resp;
    logic                  acc_write, acc_oob;
    logic [DEPTH_LOG2-1:0] acc_idx;
    word32_t               acc_data;
    word32_t               ram_q;
    logic                  unused_addr;

    assign unused_addr = &{1'b0, dmem_addr_i[1:0]};

    assign req_any   = dmem_read_i | dmem_write_i;
    assign req_valid = dmem_read_i ^ dmem_write_i;
    assign accept    = (state == IDLE) && req_valid;
    assign in_oob    = |dmem_addr_i[31:DEPTH_LOG2+2];

    assign enter_resp = (accept && (LATENCY == 1)) || ((state == BUSY) && (cnt == 4'd0));

    // With LATENCY=1 the access happens on the capture edge, so use the live request.
    always_comb begin
        acc_write = op_write;
        acc_oob   = cap_oob;
        acc_idx   = cap_idx;
        acc_data  = cap_data;
        if (state == IDLE) begin
            acc_write = dmem_write_i;
            acc_oob   = in_oob;
            acc_idx   = dmem_addr_i[DEPTH_LOG2+1:2];
            acc_data  = dmem_data_i;
        end
    end

    dmem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (clk_i),
        .en    (enter_resp && !acc_oob),
        .we    (acc_write),
        .addr  (acc_idx),
        .wdata (acc_data),
        .rdata (ram_q)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            op_write <= 1'b0;
            cap_oob  <= 1'b0;
            cap_idx  <= '0;
            cap_data <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_write <= dmem_write_i;
                    cap_oob  <= in_oob;
                    cap_idx  <= dmem_addr_i[DEPTH_LOG2+1:2];
                    cap_data <= dmem_data_i;
                    cnt      <= CNT_INIT;
                    state    <= (LATENCY == 1) ? RESP : BUSY;
                end
                BUSY: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_o <= 1'b0;
        end else if (((state == IDLE) && dmem_read_i && dmem_write_i) ||
                     ((state != IDLE) && req_any) ||
                     (accept && in_oob)) begin
            err_o <= 1'b1;
        end
    end

    assign dmem_done_o    = (state == RESP);
    assign busy_o         = (state != IDLE);
    assign dmem_rd_data_o = ((state == RESP) && !op_write && !cap_oob) ? ram_q : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: four responders (LATENCY 1..4) on one clock, table-driven
// request/response vectors plus hand sequences for collisions and reset.
module tb_dmem_responder;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        rd, wr;
    logic [3:0][31:0]  ad, wd;
    logic [3:0][31:0]  rdata;
    logic [3:0]        done, busy, err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dmem_responder #(.LATENCY(g + 1), .DEPTH_LOG2(10)) u_dut (
            .clk_i          (clk),
            .reset_i        (rst),
            .dmem_read_i    (rd[g]),
            .dmem_write_i   (wr[g]),
            .dmem_addr_i    (ad[g]),
            .dmem_data_i    (wd[g]),
            .dmem_rd_data_o (rdata[g]),
            .dmem_done_o    (done[g]),
            .busy_o         (busy[g]),
            .err_o          (err[g])
        );
    end

    typedef struct {
        int          k;
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int k, input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.k = k; v.r = r; v.w = w; v.a = a; v.d = d; v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    // Issue one request on instance k and check latency (k+1), read data and err.
    task automatic run_req(input string nm, input vec_t v);
        int n;
        bit seen;
        @(negedge clk);
        rd[v.k] = v.r; wr[v.k] = v.w; ad[v.k] = v.a; wd[v.k] = v.d;
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin rd[v.k] = 1'b0; wr[v.k] = 1'b0; end
            if (done[v.k]) begin
                seen = 1;
                chk({nm, " latency"}, n, v.k + 1);
                chk({nm, " rd_data"}, rdata[v.k], v.exp_rd);
            end
        end
        if (!seen) chk({nm, " done timeout"}, 0, 1);
        chk({nm, " err"}, {31'd0, err[v.k]}, {31'd0, v.exp_err});
    endtask

    initial begin
        int ndone, tdone;
        logic [31:0] dat;
        rd = '0; wr = '0; ad = '0; wd = '0;

        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset done%0d", k),  {31'd0, done[k]}, 32'd0);
            chk($sformatf("reset busy%0d", k),  {31'd0, busy[k]}, 32'd0);
            chk($sformatf("reset err%0d", k),   {31'd0, err[k]},  32'd0);
            chk($sformatf("reset rdata%0d", k), rdata[k],         32'd0);
        end
        rst = 1'b0;

        // k selects the instance; latency is k+1
        tbl.push_back(mk(1, 0, 1, 32'h40, 32'hDEADBEEF, 32'h0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(0, 0, 1, 32'h100 + 8 * i, 32'hA5000000 | (32'h0101 * i), 32'h0, 0));
            tbl.push_back(mk(0, 1, 0, 32'h100 + 8 * i, 32'h0, 32'hA5000000 | (32'h0101 * i), 0));
        end
        tbl.push_back(mk(1, 0, 1, 32'h0,    32'h11111111, 32'h0, 0));
        tbl.push_back(mk(1, 0, 1, 32'h1000, 32'hBADBAD00, 32'h0, 1));
        tbl.push_back(mk(1, 1, 0, 32'h0,    32'h0, 32'h11111111, 1));
        tbl.push_back(mk(1, 1, 0, 32'h1000, 32'h0, 32'h0, 1));
        tbl.push_back(mk(3, 0, 1, 32'h10, 32'hCAFEF00D, 32'h0, 0));
        tbl.push_back(mk(3, 0, 1, 32'h80, 32'h12345678, 32'h0, 0));
        tbl.push_back(mk(3, 0, 1, 32'h84, 32'h87654321, 32'h0, 0));
        tbl.push_back(mk(2, 0, 1, 32'h20, 32'h0BADF00D, 32'h0, 0));
        tbl.push_back(mk(2, 1, 0, 32'h23, 32'h0, 32'h0BADF00D, 0));

        foreach (tbl[i]) run_req($sformatf("vec%0d", i), tbl[i]);

        // Read and write together in IDLE: ignored, flagged.
        @(negedge clk);
        rd[3] = 1'b1; wr[3] = 1'b1; ad[3] = 32'h10; wd[3] = 32'hFFFFFFFF;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) begin rd[3] = 1'b0; wr[3] = 1'b0; end
            chk($sformatf("rw both done c%0d", n), {31'd0, done[3]}, 32'd0);
            chk($sformatf("rw both busy c%0d", n), {31'd0, busy[3]}, 32'd0);
        end
        chk("rw both err", {31'd0, err[3]}, 32'd1);
        run_req("rw both readback", mk(3, 1, 0, 32'h10, 32'h0, 32'hCAFEF00D, 1));

        // Second read while the first is outstanding is dropped.
        @(negedge clk);
        rd[3] = 1'b1; ad[3] = 32'h80;
        ndone = 0; tdone = 0; dat = '0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            rd[3] = (n == 2);
            if (n == 2) ad[3] = 32'h84;
            if (done[3]) begin ndone++; tdone = n; dat = rdata[3]; end
        end
        chk("overlap done count", ndone, 1);
        chk("overlap done cycle", tdone, 4);
        chk("overlap rd_data", dat, 32'h12345678);
        chk("overlap err", {31'd0, err[3]}, 32'd1);

        // Asynchronous reset mid-write aborts the commit.
        @(negedge clk);
        wr[2] = 1'b1; ad[2] = 32'h20; wd[2] = 32'h5A5A5A5A;
        @(negedge clk);
        wr[2] = 1'b0;
        chk("abort busy before reset", {31'd0, busy[2]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort done", {31'd0, done[2]}, 32'd0);
        chk("abort busy", {31'd0, busy[2]}, 32'd0);
        chk("abort rdata", rdata[2], 32'd0);
        chk("abort err cleared L4", {31'd0, err[3]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            chk($sformatf("abort no done c%0d", n), {31'd0, done[2]}, 32'd0);
        end
        run_req("abort readback", mk(2, 1, 0, 32'h20, 32'h0, 32'h0BADF00D, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
